// File: rtl/uart_rsp_if.sv
// uart_rsp_if: UART transmit side of the hash-engine link.
// Collects ack/err pulses and found nonces, builds them into byte frames and
// serializes each byte as 8N1 on tx_pin.
// Optional build macro UART_RSP_CHKSUM_EN: NONCE frames carry a sixth byte,
// the XOR of the five bytes before it.
module uart_rsp_if #(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 576000,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        ack_in,
    input  logic        err_in,
    input  logic        nonce_valid,
    output logic        nonce_ready,
    input  logic [31:0] nonce,
    input  logic [2:0]  nonce_core,
    output logic        tx_pin,
    output logic        tx_busy,
    output logic        ovf
);

    // Clocks per bit and derived widths.
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int TW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(CPB - 1);
    localparam logic [2:0]    BIT_LAST = 3'(PAYLOAD_BITS - 1);
    localparam int            FB_BYTES = 6;

`ifdef UART_RSP_CHKSUM_EN
    localparam logic [2:0] NONCE_LEN = 3'd6;
`else
    localparam logic [2:0] NONCE_LEN = 3'd5;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ERR,
        SEL_ACK,
        SEL_NONCE
    } sel_t;

    // Transmit FSM state.
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    fb_q [FB_BYTES];
    logic [7:0]    fb_d [FB_BYTES];

    // Event capture state.
    logic          ack_pend_q, ack_pend_d;
    logic          err_pend_q, err_pend_d;
    logic          nonce_full_q, nonce_full_d;
    logic [31:0]   hold_nonce_q, hold_nonce_d;
    logic [2:0]    hold_core_q, hold_core_d;
    logic          ovf_q, ovf_d;

    // Registered line outputs.
    logic          tx_pin_q, tx_pin_d;
    logic          tx_busy_q, tx_busy_d;

    // Combinational helpers.
    sel_t          sel;
    logic          arb_go;
    logic          tmr_end;
    logic          consume_err;
    logic          consume_ack;
    logic          consume_nonce;
    logic          nonce_take;
    logic [7:0]    cur_byte;
    logic [7:0]    nonce_frame [FB_BYTES];

    // NONCE frame image built straight from the holding register.
    assign nonce_frame[0] = {4'h9, 1'b0, hold_core_q};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nonce_bytes
            assign nonce_frame[gi+1] = hold_nonce_q[31-8*gi -: 8];
        end
    endgenerate

`ifdef UART_RSP_CHKSUM_EN
    assign nonce_frame[5] = nonce_frame[0] ^ nonce_frame[1] ^ nonce_frame[2]
                          ^ nonce_frame[3] ^ nonce_frame[4];
`else
    assign nonce_frame[5] = 8'h00;
`endif

    assign tmr_end  = (timer_q == TMR_LAST);
    assign cur_byte = fb_q[byte_idx_q];

    // Arbitration: only in IDLE, priority err > ack > nonce.
    always_comb begin
        sel = SEL_NONE;
        if (state_q == S_IDLE) begin
            if (err_pend_q) begin
                sel = SEL_ERR;
            end else if (ack_pend_q) begin
                sel = SEL_ACK;
            end else if (nonce_full_q) begin
                sel = SEL_NONCE;
            end
        end
    end

    assign arb_go        = (sel != SEL_NONE);
    assign consume_err   = (sel == SEL_ERR);
    assign consume_ack   = (sel == SEL_ACK);
    assign consume_nonce = (sel == SEL_NONCE);
    assign nonce_take    = nonce_valid && !nonce_full_q;

    // Pending flags, nonce holding register and sticky overflow.
    always_comb begin
        err_pend_d   = err_in || (err_pend_q && !consume_err);
        ack_pend_d   = ack_in || (ack_pend_q && !consume_ack);
        // A repeat pulse only overflows when the earlier one is still waiting.
        ovf_d        = ovf_q
                     || (err_in && err_pend_q && !consume_err)
                     || (ack_in && ack_pend_q && !consume_ack);
        nonce_full_d = nonce_take || (nonce_full_q && !consume_nonce);
        hold_nonce_d = hold_nonce_q;
        hold_core_d  = hold_core_q;
        if (nonce_take) begin
            hold_nonce_d = nonce;
            hold_core_d  = nonce_core;
        end
    end

    // Frame buffer load on the arbitration edge.
    always_comb begin
        for (int i = 0; i < FB_BYTES; i++) begin
            fb_d[i] = fb_q[i];
        end
        if (arb_go) begin
            for (int i = 0; i < FB_BYTES; i++) begin
                fb_d[i] = 8'h00;
            end
            case (sel)
                SEL_ERR: fb_d[0] = 8'hEE;
                SEL_ACK: fb_d[0] = 8'hAA;
                default: begin
                    for (int i = 0; i < FB_BYTES; i++) begin
                        fb_d[i] = nonce_frame[i];
                    end
                end
            endcase
        end
    end

    // Transmit FSM next state and bit/byte counters.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        byte_cnt_d = byte_cnt_q;
        case (state_q)
            S_IDLE: begin
                timer_d    = '0;
                bit_idx_d  = 3'd0;
                byte_idx_d = 3'd0;
                if (arb_go) begin
                    state_d    = S_START;
                    byte_cnt_d = (sel == SEL_NONCE) ? NONCE_LEN : 3'd1;
                end
            end
            S_START: begin
                if (tmr_end) begin
                    timer_d = '0;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                if (tmr_end) begin
                    timer_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        bit_idx_d = 3'd0;
                        state_d   = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                if (tmr_end) begin
                    timer_d    = '0;
                    byte_idx_d = byte_idx_q + 3'd1;
                    // Next byte starts immediately; the last one returns to IDLE.
                    if ((byte_idx_q + 3'd1) == byte_cnt_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_START;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
        endcase
    end

    // Line drive: registered, so tx_pin trails the FSM state by one cycle.
    always_comb begin
        tx_pin_d = 1'b1;
        case (state_q)
            S_START: tx_pin_d = 1'b0;
            S_DATA:  tx_pin_d = cur_byte[bit_idx_q];
            default: tx_pin_d = 1'b1;
        endcase
        // Busy covers the arbitration edge through the end of the last stop bit.
        tx_busy_d = (state_q != S_IDLE) || arb_go;
    end

    // State registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bit_idx_q    <= 3'd0;
            byte_idx_q   <= 3'd0;
            byte_cnt_q   <= 3'd0;
            for (int i = 0; i < FB_BYTES; i++) begin
                fb_q[i] <= 8'h00;
            end
            ack_pend_q   <= 1'b0;
            err_pend_q   <= 1'b0;
            nonce_full_q <= 1'b0;
            hold_nonce_q <= 32'h0;
            hold_core_q  <= 3'd0;
            ovf_q        <= 1'b0;
            tx_pin_q     <= 1'b1;
            tx_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            for (int i = 0; i < FB_BYTES; i++) begin
                fb_q[i] <= fb_d[i];
            end
            ack_pend_q   <= ack_pend_d;
            err_pend_q   <= err_pend_d;
            nonce_full_q <= nonce_full_d;
            hold_nonce_q <= hold_nonce_d;
            hold_core_q  <= hold_core_d;
            ovf_q        <= ovf_d;
            tx_pin_q     <= tx_pin_d;
            tx_busy_q    <= tx_busy_d;
        end
    end

    assign nonce_ready = !nonce_full_q;
    assign tx_pin      = tx_pin_q;
    assign tx_busy     = tx_busy_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_uart_rsp_if.sv
// Bench for uart_rsp_if at CPB=10: a line monitor decodes 8N1 bytes and
// compares them against a scoreboard queue filled when stimulus is driven.
module tb_uart_rsp_if;

    localparam int CLK_HZ   = 1000000;
    localparam int BIT_RATE = 100000;
`ifdef UART_RSP_CHKSUM_EN
    localparam int NLEN = 6;
`else
    localparam int NLEN = 5;
`endif

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        ack_in = 1'b0;
    logic        err_in = 1'b0;
    logic        nonce_valid = 1'b0;
    logic        nonce_ready;
    logic [31:0] nonce = 32'h0;
    logic [2:0]  nonce_core = 3'd0;
    logic        tx_pin;
    logic        tx_busy;
    logic        ovf;

    always #5 sys_clk = ~sys_clk;

    uart_rsp_if #(
        .CLK_HZ      (CLK_HZ),
        .BIT_RATE    (BIT_RATE),
        .PAYLOAD_BITS(8)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .ack_in     (ack_in),
        .err_in     (err_in),
        .nonce_valid(nonce_valid),
        .nonce_ready(nonce_ready),
        .nonce      (nonce),
        .nonce_core (nonce_core),
        .tx_pin     (tx_pin),
        .tx_busy    (tx_busy),
        .ovf        (ovf)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    logic       mon_en = 1'b1;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Line monitor: one decoded byte per transaction.
    int         mon_st;
    logic [7:0] mon_b;
    logic [7:0] mon_e;
    logic       mon_bad;
    always begin
        @(negedge sys_clk);
        if (tx_pin === 1'b0) begin
            mon_st  = cyc;
            mon_bad = 1'b0;
            repeat (4) @(negedge sys_clk);
            if (tx_pin !== 1'b0) mon_bad = 1'b1;
            for (int i = 0; i < 8; i++) begin
                repeat (10) @(negedge sys_clk);
                mon_b[i] = tx_pin;
            end
            repeat (10) @(negedge sys_clk);
            if (tx_pin !== 1'b1) mon_bad = 1'b1;
            if (mon_en) begin
                start_q.push_back(mon_st);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %02h at cycle %0d, no byte required", mon_b, mon_st);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_bad) begin
                        errors++;
                        $display("FAIL framing: byte %02h (required %02h) start/stop bit wrong at cycle %0d", mon_b, mon_e, mon_st);
                    end else if (mon_b !== mon_e) begin
                        errors++;
                        $display("FAIL rx_byte: got %02h, required %02h at cycle %0d", mon_b, mon_e, mon_st);
                    end else begin
                        $display("rx byte %02h at cycle %0d ok", mon_b, mon_st);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, got no event, required one", name);
    endtask

    task automatic push_nonce_frame(input logic [31:0] n, input logic [2:0] c);
        logic [7:0] b [5];
        logic [7:0] cs;
        b[0] = {4'h9, 1'b0, c};
        b[1] = n[31:24];
        b[2] = n[23:16];
        b[3] = n[15:8];
        b[4] = n[7:0];
        cs = 8'h00;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(b[i]);
            cs = cs ^ b[i];
        end
`ifdef UART_RSP_CHKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic pulse(input logic e, input logic a);
        err_in = e;
        ack_in = a;
        @(negedge sys_clk);
        err_in = 1'b0;
        ack_in = 1'b0;
    endtask

    task automatic offer_nonce(input logic [31:0] n, input logic [2:0] c);
        logic acc;
        acc = 1'b0;
        nonce = n;
        nonce_core = c;
        nonce_valid = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            acc = nonce_ready;
            @(negedge sys_clk);
            if (acc) break;
        end
        nonce_valid = 1'b0;
        if (!acc) timeout("nonce_handshake");
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || tx_busy !== 1'b0) && k < 4000) begin
            @(negedge sys_clk);
            k++;
        end
        if (k >= 4000) begin
            timeout(name);
            exp_q.delete();
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic wait_fall(input string name);
        int k;
        k = 0;
        while (tx_pin !== 1'b0 && k < 1000) begin
            @(negedge sys_clk);
            k++;
        end
        if (k >= 1000) timeout(name);
    endtask

    typedef struct {
        logic        do_err;
        logic        do_ack;
        logic        do_nonce;
        logic [31:0] nonce;
        logic [2:0]  core;
        int          exp_n;
        logic [95:0] exp_bytes;
        logic        exp_ovf;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic a, input logic n,
                                input logic [31:0] nv, input logic [2:0] c,
                                input int en, input logic [95:0] eb);
        vec_t v;
        v.do_err = e;
        v.do_ack = a;
        v.do_nonce = n;
        v.nonce = nv;
        v.core = c;
        v.exp_n = en;
        v.exp_bytes = eb;
        v.exp_ovf = 1'b0;
        return v;
    endfunction

    vec_t vecs[9];
    int   busy_cnt;
    int   low_cnt;
    int   busy_seen;

    initial begin
        vecs[0] = mk(1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 1, {8'hAA, 88'h0});
        vecs[1] = mk(1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1, {8'hEE, 88'h0});
        vecs[2] = mk(1'b1, 1'b1, 1'b0, 32'h0,        3'd0, 2, {16'hEEAA, 80'h0});
        vecs[3] = mk(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 3'd3, 5, {40'h93DEADBEEF, 56'h0});
        vecs[4] = mk(1'b0, 1'b0, 1'b1, 32'h01020304, 3'd0, 5, {40'h9001020304, 56'h0});
        vecs[5] = mk(1'b0, 1'b0, 1'b1, 32'h00000000, 3'd7, 5, {40'h9700000000, 56'h0});
        vecs[6] = mk(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 3'd5, 5, {40'h95FFFFFFFF, 56'h0});
        vecs[7] = mk(1'b1, 1'b1, 1'b1, 32'h12345678, 3'd6, 7, {56'hEEAA9612345678, 40'h0});
        vecs[8] = mk(1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 3'd1, 6, {48'hAA91A5A5A5A5, 48'h0});

        // Reset values.
        repeat (3) @(negedge sys_clk);
        check("rst_tx_pin", tx_pin, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_nonce_ready", nonce_ready, 1);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Table-driven frames.
        for (int vi = 0; vi < 9; vi++) begin
            logic [7:0] cs;
            cs = 8'h00;
            for (int k = 0; k < vecs[vi].exp_n; k++) begin
                exp_q.push_back(vecs[vi].exp_bytes[95-8*k -: 8]);
                if (k >= vecs[vi].exp_n - 5) cs = cs ^ vecs[vi].exp_bytes[95-8*k -: 8];
            end
`ifdef UART_RSP_CHKSUM_EN
            if (vecs[vi].do_nonce) exp_q.push_back(cs);
`endif
            check("vec_ready_idle", nonce_ready, 1);
            err_in = vecs[vi].do_err;
            ack_in = vecs[vi].do_ack;
            nonce_valid = vecs[vi].do_nonce;
            nonce = vecs[vi].nonce;
            nonce_core = vecs[vi].core;
            @(negedge sys_clk);
            err_in = 1'b0;
            ack_in = 1'b0;
            nonce_valid = 1'b0;
            wait_done("vec_frame_done");
            check("vec_ovf", ovf, vecs[vi].exp_ovf);
        end

        // ACK latency and busy length.
        exp_q.push_back(8'hAA);
        ack_in = 1'b1;
        @(negedge sys_clk);
        ack_in = 1'b0;
        check("lat_busy_n", tx_busy, 0);
        check("lat_pin_n", tx_pin, 1);
        @(negedge sys_clk);
        check("lat_busy_n1", tx_busy, 1);
        check("lat_pin_n1", tx_pin, 1);
        @(negedge sys_clk);
        check("lat_pin_n2", tx_pin, 0);
        busy_cnt = (tx_busy === 1'b1) ? 2 : 1;
        while (tx_busy === 1'b1 && busy_cnt < 500) begin
            @(negedge sys_clk);
            if (tx_busy === 1'b1) busy_cnt++;
        end
        check("busy_len", busy_cnt, 101);
        wait_done("ack_done");

        // ERR and ACK together: ERR first, idle gap between frames.
        start_q.delete();
        exp_q.push_back(8'hEE);
        exp_q.push_back(8'hAA);
        pulse(1'b1, 1'b1);
        wait_done("err_ack_done");
        check("err_ack_nbytes", start_q.size(), 2);
        if (start_q.size() == 2) check("frame_gap_ge_101", (start_q[1] - start_q[0]) >= 101, 1);
        check("err_ack_ovf", ovf, 0);

        // NONCE frame: ready timing and back-to-back bytes.
        start_q.delete();
        push_nonce_frame(32'hDEADBEEF, 3'd3);
        check("nonce_ready_pre", nonce_ready, 1);
        nonce = 32'hDEADBEEF;
        nonce_core = 3'd3;
        nonce_valid = 1'b1;
        @(negedge sys_clk);
        nonce_valid = 1'b0;
        check("nonce_ready_drop", nonce_ready, 0);
        @(negedge sys_clk);
        check("nonce_ready_back", nonce_ready, 1);
        check("nonce_busy_arb", tx_busy, 1);
        wait_done("nonce_done");
        check("nonce_nbytes", start_q.size(), NLEN);
        for (int i = 1; i < start_q.size(); i++) begin
            check("byte_gap", start_q[i] - start_q[i-1], 100);
        end

        // ACK re-pulsed on its own consume edge: two frames, no overflow.
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hAA);
        ack_in = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        ack_in = 1'b0;
        wait_done("repulse_done");
        check("repulse_ovf", ovf, 0);

        // Nonce stall while the holding register is full.
        exp_q.push_back(8'hEE);
        push_nonce_frame(32'h0BADF00D, 3'd2);
        push_nonce_frame(32'hCAFEF00D, 3'd4);
        pulse(1'b1, 1'b0);
        offer_nonce(32'h0BADF00D, 3'd2);
        check("stall_ready_low", nonce_ready, 0);
        offer_nonce(32'hCAFEF00D, 3'd4);
        wait_done("stall_done");
        check("stall_ovf", ovf, 0);

        // Two ACKs during an ERR frame: overflow, one ACK sent.
        exp_q.push_back(8'hEE);
        exp_q.push_back(8'hAA);
        pulse(1'b1, 1'b0);
        wait_fall("ovf_err_start");
        repeat (20) @(negedge sys_clk);
        pulse(1'b0, 1'b1);
        check("ovf_after_first", ovf, 0);
        repeat (5) @(negedge sys_clk);
        pulse(1'b0, 1'b1);
        check("ovf_after_second", ovf, 1);
        wait_done("ovf_done");
        repeat (300) @(negedge sys_clk);
        check("ovf_sticky", ovf, 1);
        exp_q.push_back(8'hAA);
        pulse(1'b0, 1'b1);
        wait_done("ovf_ack2_done");
        check("ovf_sticky2", ovf, 1);

        // Reset during DATA bit 4 of a NONCE frame.
        mon_en = 1'b0;
        offer_nonce(32'h87654321, 3'd1);
        wait_fall("rst_frame_start");
        repeat (53) @(negedge sys_clk);
        check("pre_rst_busy", tx_busy, 1);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        check("midrst_tx_pin", tx_pin, 1);
        check("midrst_tx_busy", tx_busy, 0);
        check("midrst_nonce_ready", nonce_ready, 1);
        check("midrst_ovf", ovf, 0);
        low_cnt = 0;
        busy_seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge sys_clk);
            if (tx_pin !== 1'b1) low_cnt++;
            if (tx_busy !== 1'b0) busy_seen++;
        end
        check("post_rst_tx_low_cycles", low_cnt, 0);
        check("post_rst_busy_cycles", busy_seen, 0);
        mon_en = 1'b1;

        repeat (200) @(negedge sys_clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
